// File: rtl/job_pkg.sv
`default_nettype none
// ============================================================================
// Module   : job_pkg
// Brief    : Shared types and constants for the job issuer (FSM encoding,
//            default timeout).
// Revision : 1.0 - initial release
// ============================================================================
package job_pkg;

  // Control FSM encoding
  typedef logic [2:0] state_t;

  localparam state_t c_st_idle     = 3'd0;
  localparam state_t c_st_issue    = 3'd1;
  localparam state_t c_st_wait_act = 3'd2;
  localparam state_t c_st_run      = 3'd3;
  localparam state_t c_st_resp     = 3'd4;

  // Default abort limit, in cycles spent in WAIT_ACT plus RUN
  localparam int unsigned c_timeout_default = 255;

endpackage : job_pkg
`default_nettype wire

// File: rtl/job_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : job_issuer_if
// Brief    : Host command/response and device x/on/start bundle for the job
//            issuer. slave = the issuer, master = host plus device side.
// Revision : 1.0 - initial release
// ============================================================================
interface job_issuer_if;

  // host command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [1:0] cmd_on;

  // host response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic [2:0] rsp_s;
  logic       rsp_b;
  logic [1:0] rsp_regime;
  logic       rsp_timeout;

  // device side
  logic [7:0] dev_x;
  logic [1:0] dev_on;
  logic       dev_start;
  logic [7:0] dev_y;
  logic [2:0] dev_s;
  logic       dev_b;
  logic [1:0] dev_regime;
  logic       dev_active;

  // statistics
  logic [7:0] jobs_done;

  modport slave (
    input  cmd_valid, cmd_x, cmd_on, rsp_ready,
    input  dev_y, dev_s, dev_b, dev_regime, dev_active,
    output cmd_ready, rsp_valid, rsp_y, rsp_s, rsp_b, rsp_regime, rsp_timeout,
    output dev_x, dev_on, dev_start, jobs_done
  );

  modport master (
    output cmd_valid, cmd_x, cmd_on, rsp_ready,
    output dev_y, dev_s, dev_b, dev_regime, dev_active,
    input  cmd_ready, rsp_valid, rsp_y, rsp_s, rsp_b, rsp_regime, rsp_timeout,
    input  dev_x, dev_on, dev_start, jobs_done
  );

endinterface : job_issuer_if
`default_nettype wire

// File: rtl/job_timer.sv
`default_nettype none
// ============================================================================
// Module   : job_timer
// Brief    : Per-job cycle counter; flags the last permitted cycle of a job.
// Revision : 1.0 - initial release
// ============================================================================
module job_timer
  import job_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count value seen in the final cycle before an abort is due
  localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Clear at job acceptance, advance on every waiting/running cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= 8'd0;
    end else if (en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == c_last);

endmodule : job_timer
`default_nettype wire

// File: rtl/job_issuer.sv
`default_nettype none
// ============================================================================
// Module   : job_issuer
// Brief    : Accepts a host job, starts the device, waits for it to go busy
//            and idle again, and returns the captured result (or a timeout
//            response) to the host.
// Revision : 1.0 - initial release
// ============================================================================
module job_issuer
  import job_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic         clk,
  input  logic         rst,
  job_issuer_if.slave  bus
);

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_dev_x;
  logic [1:0] r_dev_on;
  logic [7:0] r_rsp_y;
  logic [2:0] r_rsp_s;
  logic       r_rsp_b;
  logic [1:0] r_rsp_regime;
  logic       r_rsp_timeout;
  logic [7:0] r_jobs_done;

  logic       w_accept;
  logic       w_timer_en;
  logic       w_expired;
  logic       w_done;
  logic       w_abort;

  assign w_accept   = (r_state == c_st_idle) && bus.cmd_valid;
  assign w_timer_en = (r_state == c_st_wait_act) || (r_state == c_st_run);

  // Normal completion: device has dropped busy while running
  assign w_done  = (r_state == c_st_run) && !bus.dev_active;

  // Abort only when the timer is exhausted and no normal transition fires
  assign w_abort = w_expired &&
                   (((r_state == c_st_wait_act) && !bus.dev_active) ||
                    ((r_state == c_st_run)      &&  bus.dev_active));

  job_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_accept),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  // Next-state selection for the control FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:     if (w_accept) w_next = c_st_issue;
      c_st_issue:    w_next = c_st_wait_act;
      c_st_wait_act: begin
        if (bus.dev_active) w_next = c_st_run;
        else if (w_abort)   w_next = c_st_resp;
      end
      c_st_run:      if (w_done || w_abort) w_next = c_st_resp;
      c_st_resp:     if (bus.rsp_ready) w_next = c_st_idle;
      default:       w_next = c_st_idle;
    endcase
  end

  // State register plus operand/result capture and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_st_idle;
      r_dev_x       <= 8'd0;
      r_dev_on      <= 2'd0;
      r_rsp_y       <= 8'd0;
      r_rsp_s       <= 3'd0;
      r_rsp_b       <= 1'b0;
      r_rsp_regime  <= 2'd0;
      r_rsp_timeout <= 1'b0;
      r_jobs_done   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dev_x  <= bus.cmd_x;
        r_dev_on <= bus.cmd_on;
      end
      if (w_done) begin
        r_rsp_y       <= bus.dev_y;
        r_rsp_s       <= bus.dev_s;
        r_rsp_b       <= bus.dev_b;
        r_rsp_regime  <= bus.dev_regime;
        r_rsp_timeout <= 1'b0;
        r_jobs_done   <= r_jobs_done + 8'd1;
      end else if (w_abort) begin
        r_rsp_y       <= 8'd0;
        r_rsp_s       <= 3'd0;
        r_rsp_b       <= 1'b0;
        r_rsp_regime  <= 2'd0;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = (r_state == c_st_idle);
  assign bus.dev_start   = (r_state == c_st_issue);
  assign bus.rsp_valid   = (r_state == c_st_resp);
  assign bus.dev_x       = r_dev_x;
  assign bus.dev_on      = r_dev_on;
  assign bus.rsp_y       = r_rsp_y;
  assign bus.rsp_s       = r_rsp_s;
  assign bus.rsp_b       = r_rsp_b;
  assign bus.rsp_regime  = r_rsp_regime;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.jobs_done   = r_jobs_done;

endmodule : job_issuer
`default_nettype wire
